// File: rtl/cpu_pkg.sv
// Shared opcodes, condition codes, FSM states and widths for the 8-bit CPU core.
// Imported by cpu_alu and cpu_control.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 8;
  localparam int CPU_DATA_W  = 8;
  localparam int CPU_INSTR_W = 16;
  localparam int OPC_W       = 4;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_LOAD = 4'b0000;
  localparam opcode_t OP_AND  = 4'b0001;
  localparam opcode_t OP_ADD  = 4'b0100;
  localparam opcode_t OP_SUB  = 4'b0110;
  localparam opcode_t OP_JMP  = 4'b1000;
  localparam opcode_t OP_JCC  = 4'b1001;
  localparam opcode_t OP_IN   = 4'b1010;
  localparam opcode_t OP_OUT  = 4'b1110;
  localparam opcode_t OP_HALT = 4'b1111;

  localparam logic [1:0] CC_Z  = 2'b00;
  localparam logic [1:0] CC_NZ = 2'b01;
  localparam logic [1:0] CC_C  = 2'b10;
  localparam logic [1:0] CC_NC = 2'b11;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMRD  = 3'd3,
    HALT   = 3'd4
  } state_t;

  function automatic logic cc_met(input logic [1:0] cc, input logic z, input logic c);
    logic met;
    case (cc)
      CC_Z:    met = z;
      CC_NZ:   met = !z;
      CC_C:    met = c;
      default: met = !c;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for Load/Add/And/Sub; zero latency, no handshake.
// c is only meaningful for Add (carry), Sub (borrow) and And (cleared).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] k,
  input  opcode_t           op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, acc} + {1'b0, k};

  always_comb begin
    result = acc;
    c      = 1'b0;
    case (op)
      OP_LOAD: result = k;
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c      = sum[DATA_W];
      end
      OP_AND:  result = acc & k;
      OP_SUB: begin
        result = acc - k;
        c      = (acc < k);
      end
      default: ;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/cpu_control.sv
// Fetch/decode/execute sequencer: 3 cycles per instruction (Input 4); run=0 stalls in FETCH.
// CPU_HALT_EN enables opcode 1111 as a sticky HALT; otherwise 1111 is a NOP and halted is 0.
module cpu_control
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter int                INSTR_W  = CPU_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               run,
  input  logic [INSTR_W-1:0] ram_dout,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [INSTR_W-1:0] ram_din,
  output logic               ram_we,
  output logic [DATA_W-1:0]  acc_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               flag_z,
  output logic               flag_c,
  output logic               retire,
  output logic               halted
);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic [INSTR_W-1:0] ir, ir_nxt;
  logic [DATA_W-1:0]  acc, acc_nxt;
  logic               z, z_nxt;
  logic               c, c_nxt;

  opcode_t            opcode;
  logic [1:0]         cc;
  logic [DATA_W-1:0]  k;
  logic [ADDR_W-1:0]  target;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_z;
  logic               alu_c;
  logic               unused_ir_bits;

  assign opcode         = ir[INSTR_W-1 -: OPC_W];
  assign cc             = ir[INSTR_W-OPC_W-1 -: 2];
  assign k              = ir[DATA_W-1:0];
  assign target         = ir[ADDR_W-1:0];
  assign unused_ir_bits = ^ir[INSTR_W-OPC_W-3:DATA_W];

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .acc    (acc),
    .k      (k),
    .op     (opcode),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      acc   <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
      acc   <= acc_nxt;
      z     <= z_nxt;
      c     <= c_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    acc_nxt   = acc;
    z_nxt     = z;
    c_nxt     = c;
    ram_addr  = pc;
    ram_we    = 1'b0;
    retire    = 1'b0;

    case (state)
      FETCH: begin
        if (run) state_nxt = DECODE;
      end
      DECODE: begin
        ir_nxt    = ram_dout;
        state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = FETCH;
        retire    = 1'b1;
        pc_nxt    = pc + ADDR_W'(1);
        case (opcode)
          OP_LOAD: begin
            acc_nxt = alu_result;
            z_nxt   = alu_z;
          end
          OP_ADD, OP_AND, OP_SUB: begin
            acc_nxt = alu_result;
            z_nxt   = alu_z;
            c_nxt   = alu_c;
          end
          OP_IN: begin
            // Input completes in MEMRD once the registered read data arrives.
            ram_addr  = target;
            retire    = 1'b0;
            pc_nxt    = pc;
            state_nxt = MEMRD;
          end
          OP_OUT: begin
            ram_addr = target;
            ram_we   = 1'b1;
          end
          OP_JMP: pc_nxt = target;
          OP_JCC: begin
            if (cc_met(cc, z, c)) pc_nxt = target;
          end
`ifdef CPU_HALT_EN
          OP_HALT: begin
            pc_nxt    = pc;
            state_nxt = HALT;
          end
`endif
          default: ;
        endcase
      end
      MEMRD: begin
        acc_nxt   = ram_dout[DATA_W-1:0];
        z_nxt     = (ram_dout[DATA_W-1:0] == '0);
        retire    = 1'b1;
        pc_nxt    = pc + ADDR_W'(1);
        state_nxt = FETCH;
      end
`ifdef CPU_HALT_EN
      HALT: state_nxt = HALT;
`endif
      default: state_nxt = FETCH;
    endcase
  end

`ifdef CPU_HALT_EN
  assign halted = (state == HALT) || ((state == EXEC) && (opcode == OP_HALT));
`else
  assign halted = 1'b0;
`endif

  assign ram_din = {{(INSTR_W-DATA_W){1'b0}}, acc};
  assign acc_out = acc;
  assign pc_out  = pc;
  assign flag_z  = z;
  assign flag_c  = c;

endmodule

// File: tb/tb_cpu_control.sv
// Directed program run against a behavioural 256x16 RAM; expected architectural
// state per retired instruction and expected RAM writes are queued and compared.
module tb_cpu_control;

  logic        clock;
  logic        reset_n;
  logic        run;
  logic [15:0] ram_dout;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [7:0]  acc_out;
  logic [7:0]  pc_out;
  logic        flag_z;
  logic        flag_c;
  logic        retire;
  logic        halted;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] acc;
    logic       z;
    logic       c;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] wr_q[$];
  logic [15:0] mem [0:255];

  cpu_control dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .run      (run),
    .ram_dout (ram_dout),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .acc_out  (acc_out),
    .pc_out   (pc_out),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .retire   (retire),
    .halted   (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read RAM; read-after-write returns the new word.
  always @(posedge clock) begin
    ram_dout <= ram_we ? ram_din : mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] pc, input logic [7:0] acc,
                      input logic z, input logic c, input int lat);
    exp_t e;
    e.pc = pc; e.acc = acc; e.z = z; e.c = c; e.lat = lat;
    sb.push_back(e);
  endtask

  // Called at a negedge in FETCH; returns at the FETCH negedge after the n-th retire.
  task automatic run_retires(input int n);
    int          got;
    int          cyc;
    int          guard;
    bit          pend;
    exp_t        cur;
    logic [23:0] w;
    got = 0; cyc = 1; guard = 0; pend = 0;
    while (got < n || pend) begin
      @(negedge clock);
      cyc++;
      guard++;
      if (guard > 40 * n) begin
        chk("retire_timeout", got, n);
        return;
      end
      if (pend) begin
        chk("pc", pc_out, cur.pc);
        chk("acc", acc_out, cur.acc);
        chk("flag_z", flag_z, cur.z);
        chk("flag_c", flag_c, cur.c);
        pend = 0;
      end
      if (ram_we) begin
        if (wr_q.size() == 0) chk("unexpected_we", ram_we, 0);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", ram_addr, w[23:16]);
          chk("wr_data", ram_din, w[15:0]);
        end
      end
      if (retire) begin
        if (sb.size() == 0) chk("unexpected_retire", retire, 0);
        else begin
          cur = sb.pop_front();
          chk("latency", cyc, cur.lat);
          pend = 1;
          got++;
        end
        cyc = 0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit we_seen;
    bit ret_seen;
    bit pc_moved;

    reset_n = 1'b0;
    run     = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

    mem[8'h00] = 16'hA006; mem[8'h01] = 16'h400A; mem[8'h02] = 16'h9C04;
    mem[8'h03] = 16'h8010; mem[8'h06] = 16'h00FA;
    mem[8'h10] = 16'h00FF; mem[8'h11] = 16'hE007; mem[8'h12] = 16'h0000;
    mem[8'h13] = 16'hA007; mem[8'h14] = 16'h0005; mem[8'h15] = 16'h6005;
    mem[8'h16] = 16'h9020;
    mem[8'h20] = 16'h0003; mem[8'h21] = 16'h6005; mem[8'h22] = 16'h9030;
    mem[8'h23] = 16'h100F; mem[8'h24] = 16'h9840; mem[8'h25] = 16'h9440;
    mem[8'h40] = 16'h1000; mem[8'h41] = 16'h20AB; mem[8'h42] = 16'h80FF;
    mem[8'hFF] = 16'h4000;

    repeat (3) @(negedge clock);
    chk("rst_pc", pc_out, 8'h00);
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_z", flag_z, 0);
    chk("rst_c", flag_c, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);

    //   pc     acc    z  c  lat
    push(8'h01, 8'hFA, 0, 0, 4);   // Input 6
    push(8'h02, 8'h04, 0, 1, 3);   // Add 10 -> carry
    push(8'h03, 8'h04, 0, 1, 3);   // JNC not taken
    push(8'h10, 8'h04, 0, 1, 3);   // Jump 10
    push(8'h11, 8'hFF, 0, 1, 3);   // Load FF
    push(8'h12, 8'hFF, 0, 1, 3);   // Output 7
    wr_q.push_back({8'h07, 16'h00FF});
    push(8'h13, 8'h00, 1, 1, 3);   // Load 0
    push(8'h14, 8'hFF, 0, 1, 4);   // Input 7 (written word)
    push(8'h15, 8'h05, 0, 1, 3);   // Load 5
    push(8'h16, 8'h00, 1, 0, 3);   // Sub 5 -> zero
    push(8'h20, 8'h00, 1, 0, 3);   // JZ taken
    push(8'h21, 8'h03, 0, 0, 3);   // Load 3
    push(8'h22, 8'hFE, 0, 1, 3);   // Sub 5 -> borrow
    push(8'h23, 8'hFE, 0, 1, 3);   // JZ not taken
    push(8'h24, 8'h0E, 0, 0, 3);   // And 0F
    push(8'h25, 8'h0E, 0, 0, 3);   // JC not taken
    push(8'h40, 8'h0E, 0, 0, 3);   // JNZ taken
    push(8'h41, 8'h00, 1, 0, 3);   // And 0
    push(8'h42, 8'h00, 1, 0, 3);   // NOP opcode 0010
    push(8'hFF, 8'h00, 1, 0, 3);   // Jump FF
    push(8'h00, 8'h00, 1, 0, 3);   // Add 0 at FF, pc wraps

    @(negedge clock);
    reset_n = 1'b1;
    run     = 1'b1;
    run_retires(21);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("sb_drained", sb.size(), 0);

    // Hold at the instruction boundary.
    run = 1'b0;
    we_seen = 0; ret_seen = 0;
    repeat (10) begin
      @(negedge clock);
      we_seen  |= ram_we;
      ret_seen |= retire;
    end
    chk("hold_pc", pc_out, 8'h00);
    chk("hold_we", we_seen, 0);
    chk("hold_retire", ret_seen, 0);

    // Reset during Output EXEC drops ram_we without a clock edge.
    mem[8'h00] = 16'h0055;
    mem[8'h01] = 16'hE009;
    push(8'h01, 8'h55, 0, 0, 3);
    run = 1'b1;
    run_retires(1);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("out_we", ram_we, 1);
    chk("out_addr", ram_addr, 8'h09);
    chk("out_din", ram_din, 16'h0055);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_we", ram_we, 0);
    chk("arst_pc", pc_out, 8'h00);
    chk("arst_acc", acc_out, 8'h00);
    chk("arst_retire", retire, 0);

    // Opcode 1111: HALT with the feature, NOP without.
    mem[8'h00] = 16'hF000;
    mem[8'h01] = 16'h0077;
    @(negedge clock);
    reset_n = 1'b1;
    run     = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("op_f_retire", retire, 1);
`ifdef CPU_HALT_EN
    chk("halt_exec_halted", halted, 1);
    @(posedge clock);
    we_seen = 0; ret_seen = 0; pc_moved = 0;
    repeat (20) begin
      @(negedge clock);
      we_seen  |= ram_we;
      ret_seen |= retire;
      pc_moved |= (pc_out != 8'h00);
    end
    chk("halt_halted", halted, 1);
    chk("halt_we", we_seen, 0);
    chk("halt_retire", ret_seen, 0);
    chk("halt_pc_frozen", pc_moved, 0);
`else
    chk("nop_f_halted", halted, 0);
    @(posedge clock);
    #1;
    chk("nop_f_pc", pc_out, 8'h01);
    chk("nop_f_halted_after", halted, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Fetch/decode/execute sequencer for the 8-bit CPU. It is the direct consumer of the 256x16 program/data RAM.
- Drives the RAM address, write-enable and write data. Consumes the registered RAM read data, which appears one clock after the address is sampled.
- Holds PC, IR, ACC and the Z/C flags, and executes the 16-bit instruction set.

Parameters:
- ADDR_W, 8, RAM address and PC width.
- DATA_W, 8, accumulator and immediate width.
- INSTR_W, 16, instruction and RAM word width.
- RESET_PC, 8'h00, PC value after reset.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  sampled in FETCH only; 0 holds the core at the instruction boundary.
- ram_dout  in  16  RAM read data, valid the cycle after the address was presented.
- ram_addr  out  8  RAM address (combinational from state/PC/IR).
- ram_din  out  16  RAM write data = {8'h00, acc}.
- ram_we  out  1  RAM write enable.
- acc_out  out  8  accumulator.
- pc_out  out  8  program counter.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- retire  out  1  high during the last cycle of each instruction.
- halted  out  1  high in HALT state (tied 0 without the optional feature).

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, acc=0, ir=0, Z=0, C=0, state=FETCH. Outputs: ram_we=0, retire=0, halted=0. Reset mid-Output drops ram_we immediately.
- FETCH: ram_addr=pc.
  - run=1 -> DECODE.
  - run=0 -> stay in FETCH; no state changes.
- DECODE: ir <= ram_dout -> EXEC.
- EXEC, by ir[15:12]:
  - 0000 Load: acc=k; Z=(k==0); C unchanged.
  - 0100 Add: {C,acc}=acc+k (9-bit); Z=(result[7:0]==0).
  - 0001 And: acc=acc&k; C=0; Z updated.
  - 0110 Sub: acc=acc-k mod 256; C=(acc<k), i.e. borrow; Z updated.
  - 1010 Input: ram_addr=ir[7:0] -> MEMRD; pc not yet advanced.
  - 1110 Output: ram_addr=ir[7:0], ram_we=1, ram_din={8'h00,acc}; flags unchanged.
  - 1000 Jump U: pc=ir[7:0].
  - 1001 Jump conditional, condition from ir[11:10]:
    - 00 = Z
    - 01 = NZ
    - 10 = C
    - 11 = NC
    - Taken: pc=ir[7:0]; otherwise pc+1.
  - All other opcodes: NOP.
- k is ir[7:0] throughout.
- MEMRD: acc=ram_dout[7:0]; Z updated; C unchanged.
- Instruction completion:
  - Non-jump instructions complete with pc=pc+1 mod 256 (255 wraps to 0).
  - retire=1 in the completing cycle (EXEC, or MEMRD for Input). Next state is FETCH.
- Latency: 3 cycles for all instructions except Input, which takes 4.
- ram_we is high only in EXEC of Output. The RAM's read-after-write returns the new word; the controller ignores it.
- Jump to own address is legal and loops forever.

Optional Feature:
- Macro: CPU_HALT_EN.
- Defined: opcode 1111 enters HALT.
  - halted=1 and retire=1 in that EXEC cycle. pc is not incremented.
  - The core stays in HALT until reset; ram_we=0 throughout.
- Undefined: 1111 is a NOP and halted is tied 0.

Decomposition:
- Package cpu_pkg holds:
  - Opcode constants: OP_LOAD, OP_ADD, OP_AND, OP_SUB, OP_IN, OP_OUT, OP_JMP, OP_JCC, OP_HALT.
  - Condition codes: CC_Z, CC_NZ, CC_C, CC_NC.
  - FSM state encoding: FETCH, DECODE, EXEC, MEMRD, HALT.
  - Width constants.
- Sub-module cpu_alu: purely combinational. Inputs acc, k, op. Outputs result, z, c.
- The sequencer FSM and registers stay in cpu_control.

Test Plan:
- Reset then run=1 with mem[0]=A006, mem[6]=00FA -> after 4 cycles acc=250, pc=1, retire pulsed once.
- Add 10 with acc=250 -> acc=4, C=1, Z=0. Then Jump NC 4 (9C04) at pc=2 is not taken -> pc=3.
- Load 255 then Output 7 (E007) -> ram_we=1 for one cycle, ram_addr=7, ram_din=00FF. The subsequent Input 7 returns acc=255.
- Sub: acc=5, Sub 5 -> acc=0, Z=1, C=0. Then acc=3, Sub 5 -> acc=254, C=1. Jump Z (9000 | aa) taken only in the first case.
- Jump U to 255 (80FF), mem[255]=Add 0 -> pc wraps to 0 after execution. run=0 in FETCH holds pc and never asserts ram_we.
- Assert reset_n=0 during Output EXEC -> ram_we falls without a clock edge; pc=0, acc=0. With CPU_HALT_EN, F000 -> halted=1, pc frozen for 20 cycles.
